// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, mode constants and bit reversal for the FFT reorder buffer
package fft_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2,
    BANK_READ  = 2'd3
  } bank_st_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_st_t;

  localparam logic [1:0] MODE_RAW   = 2'b00;
  localparam logic [1:0] MODE_NAT   = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;

  // Reverses the low n bits of x; callers size-cast the result to n bits.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r >> (32 - n);
  endfunction

endpackage

// File: rtl/fft_rb_ram.sv
// rtl/fft_rb_ram.sv - simple dual-port synchronous RAM holding both ping-pong banks
module fft_rb_ram #(
  parameter int WIDTH = 16,
  parameter int N     = 9
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [N:0]         wr_addr,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [N:0]         rd_addr,
  output logic [2*WIDTH-1:0] rd_data
);

  logic [2*WIDTH-1:0] mem [1 << (N+1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_reorder_buf.sv
// rtl/fft_reorder_buf.sv - ping-pong buffer turning corefft bit-reversed frames into raw/natural/fftshift order
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N      = 9,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              din_en,
  input  logic [N-1:0]      din_cnt,
  input  logic [WIDTH-1:0]  din_re,
  input  logic [WIDTH-1:0]  din_im,
  input  logic [MODE_W-1:0] mode,
  output logic              dout_en,
  output logic [N-1:0]      dout_cnt,
  output logic              dout_last,
  output logic [WIDTH-1:0]  dout_re,
  output logic [WIDTH-1:0]  dout_im,
  output logic              sync_err,
  output logic              ovf_err
);

  localparam logic [N-1:0] LAST = '1;
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

  bank_st_t          bank_st   [2];
  logic [MODE_W-1:0] bank_mode [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [N-1:0]      prev_cnt;
  rd_st_t            rd_st;
  logic [N-1:0]      rd_r;

  logic              wb_filling, wb_free, seq_ok, restart, claim, ovf;
  logic              rd_en, rd_release, wr_en;
  logic [MODE_W-1:0] wr_mode;
  logic [N-1:0]      din_rev, rd_a;
  logic [N:0]        wr_addr, rd_addr;
  logic [2*WIDTH-1:0] rd_data;

  logic              s1_en, s1_last;
  logic [N-1:0]      s1_cnt;

  assign rd_en      = (rd_st == RD_RUN);
  assign rd_release = rd_en && (rd_r == LAST);
  assign wb_filling = (bank_st[wr_ptr] == BANK_FILL);
  // A bank being released this cycle can be reclaimed at once, so full-rate writes never stall.
  assign wb_free    = (bank_st[wr_ptr] == BANK_EMPTY) || (rd_release && (rd_ptr == wr_ptr));
  assign seq_ok     = (din_cnt == prev_cnt + 1'b1);
  assign restart    = din_en && wb_filling && !seq_ok && (din_cnt == '0);
  assign claim      = restart || (din_en && !wb_filling && wb_free && (din_cnt == '0));
  assign ovf        = din_en && !wb_filling && !wb_free;
  assign wr_en      = claim || (din_en && wb_filling);
  assign wr_mode    = claim ? mode : bank_mode[wr_ptr];
  assign din_rev    = N'(bitrev(32'(din_cnt), N));
  assign wr_addr    = {wr_ptr, (wr_mode == MODE_RAW) ? din_cnt : din_rev};
  assign rd_a       = (bank_mode[rd_ptr] == MODE_SHIFT) ? (rd_r ^ HALF) : rd_r;
  assign rd_addr    = {rd_ptr, rd_a};

  fft_rb_ram #(.WIDTH(WIDTH), .N(N)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({din_re, din_im}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Read side updates first; a same-cycle write-side claim of the released bank overrides it.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bank_st[0]   <= BANK_EMPTY;
      bank_st[1]   <= BANK_EMPTY;
      bank_mode[0] <= '0;
      bank_mode[1] <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      prev_cnt     <= '0;
      rd_st        <= RD_IDLE;
      rd_r         <= '0;
      sync_err     <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      if (rd_st == RD_IDLE) begin
        if (bank_st[rd_ptr] == BANK_FULL) begin
          rd_st            <= RD_RUN;
          bank_st[rd_ptr]  <= BANK_READ;
          rd_r             <= '0;
        end
      end else begin
        rd_r <= rd_r + 1'b1;
        if (rd_release) begin
          bank_st[rd_ptr] <= BANK_EMPTY;
          rd_ptr          <= ~rd_ptr;
          if (bank_st[~rd_ptr] == BANK_FULL) bank_st[~rd_ptr] <= BANK_READ;
          else rd_st <= RD_IDLE;
        end
      end

      if (claim) begin
        bank_st[wr_ptr]   <= BANK_FILL;
        bank_mode[wr_ptr] <= mode;
        prev_cnt          <= '0;
      end else if (din_en && wb_filling) begin
        prev_cnt <= din_cnt;
        if (!seq_ok) sync_err <= 1'b1;
        if (din_cnt == LAST) begin
          bank_st[wr_ptr] <= BANK_FULL;
          wr_ptr          <= ~wr_ptr;
        end
      end
      if (restart) sync_err <= 1'b1;
      if (ovf)     ovf_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s1_en     <= 1'b0;
      s1_cnt    <= '0;
      s1_last   <= 1'b0;
      dout_en   <= 1'b0;
      dout_cnt  <= '0;
      dout_last <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
    end else begin
      s1_en     <= rd_en;
      s1_cnt    <= rd_a;
      s1_last   <= rd_release;
      dout_en   <= s1_en;
      dout_last <= s1_last;
      if (s1_en) begin
        dout_cnt <= s1_cnt;
        dout_re  <= rd_data[2*WIDTH-1:WIDTH];
        dout_im  <= rd_data[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb/tb_fft_reorder_buf.sv - randomized self-checking bench for fft_reorder_buf
module tb_fft_reorder_buf;

  localparam int WIDTH = 16;
  localparam int N     = 9;
  localparam int LEN   = 1 << N;
  localparam int HALF  = LEN / 2;

  logic             clk = 1'b0;
  logic             areset;
  logic             din_en;
  logic [N-1:0]     din_cnt;
  logic [WIDTH-1:0] din_re, din_im;
  logic [1:0]       mode;
  logic             dout_en, dout_last, sync_err, ovf_err;
  logic [N-1:0]     dout_cnt;
  logic [WIDTH-1:0] dout_re, dout_im;

  fft_reorder_buf #(.WIDTH(WIDTH), .N(N), .MODE_W(2)) dut (
    .clk       (clk),
    .areset    (areset),
    .din_en    (din_en),
    .din_cnt   (din_cnt),
    .din_re    (din_re),
    .din_im    (din_im),
    .mode      (mode),
    .dout_en   (dout_en),
    .dout_cnt  (dout_cnt),
    .dout_last (dout_last),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .sync_err  (sync_err),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]     cnt;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic             last;
    int               cyc;
  } out_t;

  typedef struct {
    logic [N-1:0]     cnt;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic             last;
    bit               known;
  } exp_t;

  out_t out_q[$];
  exp_t exp_q[$];

  logic [WIDTH-1:0] frm_re [LEN];
  logic [WIDTH-1:0] frm_im [LEN];
  bit               frm_known [LEN];
  int               last_in_cyc;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dout_en === 1'b1) begin
      out_t o;
      o.cnt  = dout_cnt;
      o.re   = dout_re;
      o.im   = dout_im;
      o.last = dout_last;
      o.cyc  = cyc;
      out_q.push_back(o);
    end
  end

  function automatic int rev(input int x);
    int y = 0;
    for (int i = 0; i < N; i++) begin
      y = y * 2 + x % 2;
      x = x / 2;
    end
    return y;
  endfunction

  // Output position r shows bin r (natural), bin r+LEN/2 mod LEN (fftshift) or raw slot r.
  task automatic add_expected(input int m);
    for (int r = 0; r < LEN; r++) begin
      int   bin, src;
      exp_t e;
      if (m == 0) begin
        bin = r;
        src = r;
      end else if (m == 2) begin
        bin = (r + HALF) % LEN;
        src = rev(bin);
      end else begin
        bin = r;
        src = rev(r);
      end
      e.cnt   = N'(bin);
      e.re    = frm_re[src];
      e.im    = frm_im[src];
      e.known = frm_known[src];
      e.last  = (r == LEN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int c, input int m);
    din_en  = 1'b1;
    din_cnt = N'(c);
    din_re  = frm_re[c];
    din_im  = frm_im[c];
    mode    = (c == 0) ? 2'(m) : 2'($urandom);
    @(posedge clk);
    #1;
    din_en      = 1'b0;
    last_in_cyc = cyc;
  endtask

  task automatic send_frame(input int m, input bit gaps);
    for (int c = 0; c < LEN; c++) begin
      send_one(c, m);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < LEN; c++) begin
      frm_re[c]    = WIDTH'($urandom);
      frm_im[c]    = WIDTH'($urandom);
      frm_known[c] = 1'b1;
    end
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (out_q.size() < n && t < 4000) begin
      @(posedge clk);
      t++;
    end
    idle(20);
  endtask

  task automatic compare(input string tag, input bit contig, input bit lat);
    int mism = 0;
    int gaps = 0;
    int n;
    chk({tag, " count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (out_q[i].cnt !== exp_q[i].cnt || out_q[i].last !== exp_q[i].last ||
          (exp_q[i].known && (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im)))
        mism++;
      if (i > 0 && out_q[i].cyc != out_q[i-1].cyc + 1) gaps++;
    end
    chk({tag, " data"}, mism, 0);
    if (contig) chk({tag, " gaps"}, gaps, 0);
    if (lat && out_q.size() > 0) chk({tag, " latency"}, out_q[0].cyc - last_in_cyc, 3);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    din_en = 1'b0;
    idle(3);
    areset = 1'b0;
    idle(2);
    out_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f1;
    areset  = 1'b1;
    din_en  = 1'b0;
    din_cnt = '0;
    din_re  = '0;
    din_im  = '0;
    mode    = '0;
    idle(3);
    chk("reset dout_en", dout_en, 0);
    chk("reset dout_cnt", dout_cnt, 0);
    chk("reset dout_last", dout_last, 0);
    chk("reset dout_re_im", {dout_re, dout_im}, 0);
    chk("reset errs", {sync_err, ovf_err}, 0);
    areset = 1'b0;
    idle(2);

    for (int c = 0; c < LEN; c++) begin
      frm_re[c]    = WIDTH'(rev(c));
      frm_im[c]    = '0;
      frm_known[c] = 1'b1;
    end
    send_frame(1, 1'b1);
    add_expected(1);
    wait_out(LEN);
    compare("t1_natural", 1'b1, 1'b1);

    send_frame(2, 1'b0);
    add_expected(2);
    wait_out(LEN);
    compare("t2_shift", 1'b1, 1'b1);
    send_frame(0, 1'b0);
    add_expected(0);
    wait_out(LEN);
    compare("t2_raw", 1'b1, 1'b1);
    send_frame(3, 1'b1);
    add_expected(3);
    wait_out(LEN);
    compare("t2_reserved", 1'b1, 1'b1);

    fill_rand();
    send_frame(1, 1'b0);
    add_expected(1);
    f1 = last_in_cyc;
    fill_rand();
    send_frame(2, 1'b0);
    add_expected(2);
    fill_rand();
    send_frame(1, 1'b0);
    add_expected(1);
    wait_out(3 * LEN);
    last_in_cyc = f1;
    compare("t3_b2b", 1'b1, 1'b1);
    chk("t3 ovf_err", ovf_err, 0);
    chk("t3 sync_err", sync_err, 0);

    fill_rand();
    frm_known[100] = 1'b0;
    for (int c = 0; c < LEN; c++) if (c != 100) send_one(c, 1);
    add_expected(1);
    wait_out(LEN);
    compare("t4_jump", 1'b1, 1'b1);
    chk("t4 sync_err set", sync_err, 1);

    fill_rand();
    for (int c = 0; c < 200; c++) send_one(c, 0);
    fill_rand();
    send_frame(2, 1'b0);
    add_expected(2);
    wait_out(LEN);
    compare("t4_restart", 1'b1, 1'b1);
    chk("t4 sync_err sticky", sync_err, 1);

    do_reset();
    chk("t5 errs cleared", {sync_err, ovf_err}, 0);
    fill_rand();
    send_frame(1, 1'b0);
    add_expected(1);
    f1 = last_in_cyc;
    fill_rand();
    for (int c = 0; c < LEN; c++) frm_known[c] = (c < 10) || (c == LEN - 1);
    for (int c = 0; c < 10; c++) send_one(c, 1);
    send_one(LEN - 1, 1);
    add_expected(1);
    fill_rand();
    send_frame(1, 1'b0);
    wait_out(2 * LEN);
    last_in_cyc = f1;
    compare("t5_ovf", 1'b1, 1'b1);
    chk("t5 ovf_err", ovf_err, 1);

    do_reset();
    fill_rand();
    send_frame(1, 1'b0);
    fill_rand();
    for (int c = 0; c < 300; c++) send_one(c, 1);
    chk("t6 readout active", dout_en, 1);
    areset = 1'b1;
    #1;
    chk("t6 reset dout_en", dout_en, 0);
    chk("t6 reset dout_fields", {dout_cnt, dout_last, dout_re, dout_im}, 0);
    chk("t6 reset errs", {sync_err, ovf_err}, 0);
    idle(2);
    areset = 1'b0;
    out_q.delete();
    exp_q.delete();
    for (int c = 300; c < LEN; c++) send_one(c, 1);
    idle(600);
    chk("t6 no output after reset", out_q.size(), 0);
    fill_rand();
    send_frame(2, 1'b1);
    add_expected(2);
    wait_out(LEN);
    compare("t6_after_reset", 1'b1, 1'b1);
    chk("t6 errs", {sync_err, ovf_err}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
Ping-pong output reorder buffer placed directly after corefft. It captures one complete FFT frame in bit-reversed bin order and replays it as a gap-free frame. The replay order is selectable per frame: raw order, natural bin order, or natural order with the DC bin moved to the centre (fftshift). It is parametrised in sample width and log2 frame length, and it reports sync and overflow errors.

Parameters:
WIDTH, 16, signed bit width of each real and imaginary component
N, 9, log2 of frame length; frame length is 2^N points
MODE_W, 2, width of the order-mode field (fixed by the mode encoding; not for override)

Ports:
clk  in  1  system clock, rising edge
areset  in  1  asynchronous reset, active-high
din_en  in  1  input sample valid
din_cnt  in  N  index of the input sample within its frame (FFT output order)
din_re  in  WIDTH  signed input real part
din_im  in  WIDTH  signed input imaginary part
mode  in  2  order mode: 00 raw, 01 natural, 10 fftshift, 11 reserved (treated as 01)
dout_en  out  1  output sample valid
dout_cnt  out  N  output bin index in replay order
dout_last  out  1  high with the final sample of an output frame
dout_re  out  WIDTH  signed output real part
dout_im  out  WIDTH  signed output imaginary part
sync_err  out  1  sticky: din_cnt sequence violation seen
ovf_err  out  1  sticky: input sample dropped because no bank was free

Behaviour:
- Storage: two banks, each 2^N x 2*WIDTH, using synchronous-read RAM. RAM contents are not reset.
- Bank states are EMPTY, FILL, FULL and READ. Each bank also holds a latched mode.
- Write side:
  - A sample with din_en=1 and din_cnt=0 claims the write bank, which must be EMPTY. The bank moves to FILL and latches mode.
  - Write address = bitrev_N(din_cnt) for modes 01/10/11, and din_cnt for mode 00.
  - When din_en=1 and din_cnt=2^N-1 in FILL, the bank goes to FULL and the write pointer toggles to the other bank.
- Sequence check: inside FILL, each din_en sample must carry the previous din_cnt+1.
  - On a mismatch, set sync_err.
  - If the mismatched din_cnt=0, restart the frame in the same bank (abandon the partial frame, relatch mode). Otherwise keep writing.
- Overflow: if din_en=1 while the write bank is not EMPTY/FILL, drop the sample and set ovf_err. Samples with din_cnt!=0 and no bank in FILL are dropped silently.
- Read side:
  - The FSM has states IDLE and RUN.
  - In IDLE, when the read bank is FULL, go to RUN the next cycle, mark the bank READ, and set the address counter r=0.
  - In RUN, issue read address A(r) each cycle, with r incrementing 0..2^N-1:
    - mode 00/01: A=r
    - mode 10: A=r XOR 2^(N-1)
  - The bank goes EMPTY in the same cycle the last address is issued, and the read pointer toggles.
  - If the other bank is already FULL at that point, RUN continues with r=0 with no bubble. Otherwise the FSM returns to IDLE.
- Output register stage: dout_re/dout_im come from the RAM via one output register.
  - dout_cnt = A(r) for mode 10, r otherwise.
  - dout_last is high when r=2^N-1.
  - dout_en, dout_cnt and dout_last are delayed to align with the data.
- Latency: if the last sample of a frame is sampled at edge E, bin 0 appears with dout_en=1 after edge E+3. This holds when the read side is idle.
- Throughput: sustained 1 sample/cycle with no loss. The write side never overtakes the read side at full rate.
- Reset (any time, including mid-frame): both banks go EMPTY, FSM to IDLE. dout_en, dout_cnt, dout_last, dout_re, dout_im, sync_err and ovf_err all go to 0. No output is produced until a new complete frame has been written.
- No arithmetic is performed; data passes bit-exact.

Decomposition:
- Shared package fft_pkg:
  - bank-state encoding
  - mode constants (MODE_RAW, MODE_NAT, MODE_SHIFT)
  - bitrev function parametrised by N
- One sub-module, fft_rb_ram: a simple dual-port synchronous RAM, depth 2^(N+1), width 2*WIDTH. The bank is selected by the address MSB.

Test Plan:
1. N=9, mode=01, one frame where din_cnt=0..511 and din_re=bitrev(din_cnt), din_im=0 → 3 cycles after the last input, 512 consecutive dout_en. dout_cnt=k, dout_re=k, dout_last only at k=511.
2. Same frame with mode=10 → dout_cnt sequence 256..511,0..255, dout_re equal to dout_cnt. Mode=00 → dout_re=bitrev(k) at position k.
3. Three back-to-back frames at 1 sample/cycle with alternating modes 01/10/01 → 1536 contiguous dout_en with no bubble. Each frame uses its own latched mode. ovf_err=0, sync_err=0.
4. Frame with din_cnt jumping 99→101 → sync_err=1 and stays high. The frame is still output. Then din_cnt=0 injected mid-frame → the partial frame is discarded and only the restarted frame is output.
5. Read side kept busy while a third frame arrives before any bank is free (write two frames, stall none, then reset-free burst) → dropped samples set ovf_err=1. The data of the first two frames is unaffected.
6. areset asserted at sample 300 of frame 2 during readout of frame 1 → all outputs 0 immediately. After release, no dout_en until a new full frame. That frame is output correctly with latency 3.
